vedic_mult_seq: RTL



---
 rtl/vedic_pkg.sv | 25 ++
 rtl/vedic_col_sum.sv | 36 +++
 rtl/vedic_mult_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// Shared types and helpers for the column-serial Urdhva-Tiryagbhyam multiplier.
package vedic_pkg;

    localparam int unsigned MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    function automatic int unsigned carry_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [3:0] popcount(input logic [MAX_N-1:0] bits);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vedic_col_sum.sv
// Combinational column reducer: diagonal partial products of one column plus incoming carry.
module vedic_col_sum
    import vedic_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned CW   = carry_width(N),
    parameter int unsigned COLW = $clog2(2 * N)
) (
    input  logic [N-1:0]    a_reg,
    input  logic [N-1:0]    b_reg,
    input  logic [COLW-1:0] col,
    input  logic [CW-1:0]   carry_in,
    output logic            sum_bit,
    output logic [CW-1:0]   carry_out
);

    logic [MAX_N-1:0] diag;
    logic [CW-1:0]    sum;

    // Column sum is at most 2N-1, which always fits in CW bits.
    always_comb begin
        diag = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i + j == int'(col)) begin
                    diag[i] = a_reg[i] & b_reg[j];
                end
            end
        end
        sum = CW'(popcount(diag)) + carry_in;
    end

    assign sum_bit   = sum[0];
    assign carry_out = sum >> 1;

endmodule

// File: rtl/vedic_mult_seq.sv
// Column-serial multiplier top: one product column per cycle, valid/ready on both sides.
// Optional VEDIC_SELFCHECK_EN builds a sticky err comparator against a behavioural product.
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = carry_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           err
);

    localparam int unsigned PW   = 2 * N;
    localparam int unsigned COLW = $clog2(PW);
    localparam logic [COLW-1:0] LAST = COLW'(PW - 2);

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [COLW-1:0] col_q, col_d;
    logic [CW-1:0]   carry_q, carry_d, carry_out;
    logic [PW-1:0]   p_q, p_d;
    logic            sum_bit;

    vedic_col_sum #(
        .N    (N),
        .CW   (CW),
        .COLW (COLW)
    ) u_col_sum (
        .a_reg     (a_q),
        .b_reg     (b_q),
        .col       (col_q),
        .carry_in  (carry_q),
        .sum_bit   (sum_bit),
        .carry_out (carry_out)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        col_d   = col_q;
        carry_d = carry_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = '0;
                    p_d     = '0;
                    col_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                p_d[col_q] = sum_bit;
                carry_d    = carry_out;
                col_d      = col_q + COLW'(1);
                // Last column: the leftover carry is the product MSB.
                if (col_q == LAST) begin
                    p_d[PW-1] = carry_out[0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            col_q   <= '0;
            carry_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            col_q   <= col_d;
            carry_q <= carry_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

`ifdef VEDIC_SELFCHECK_EN
    logic          err_q, err_d;
    logic [PW-1:0] ref_prod;

    assign ref_prod = PW'(a_q) * PW'(b_q);

    always_comb begin
        err_d = err_q;
        if (state_q == COMPUTE && col_q == LAST && p_d != ref_prod) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
